// File: rtl/demux_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with per-packet destination lock and a single-entry output buffer.
// Optional per-channel 16-bit output beat counters are enabled by defining DEMUX_4_BEAT_CNT_EN.
module demux_4_stream #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready
`ifdef DEMUX_4_BEAT_CNT_EN
  ,
  output logic [63:0]       beat_cnt
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [1:0]        lock_sel;
  logic [1:0]        route;
  logic              accept;
  logic              drain;

  logic              vld_p0;
  logic [1:0]        dest_p0;
  logic [DATA_W-1:0] data_p0;
  logic              last_p0;

  // Only the destination channel's ready matters; a stalled channel blocks everything.
  assign drain     = vld_p0 & out_ready[dest_p0];
  assign in_ready  = ~vld_p0 | out_ready[dest_p0];
  assign accept    = in_valid & in_ready;
  assign route     = (state == LOCKED) ? lock_sel : sel;

  assign out_valid = vld_p0 ? (4'b0001 << dest_p0) : 4'b0000;
  assign out_data  = data_p0;
  assign out_last  = last_p0;

  // Stage p0: output buffer; simultaneous drain and accept keeps it full with new contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      dest_p0 <= 2'd0;
      data_p0 <= '0;
      last_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      dest_p0 <= route;
      data_p0 <= in_data;
      last_p0 <= in_last;
    end else if (drain) begin
      vld_p0  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_sel <= 2'd0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!in_last) begin
            lock_sel <= sel;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_4_BEAT_CNT_EN
  logic [3:0][15:0] cnt;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (drain) begin
      cnt[dest_p0] <= cnt[dest_p0] + 16'd1;
    end
  end

  assign beat_cnt = cnt;
`endif

endmodule

// File: tb/tb_demux_4_stream.sv
// Scoreboard bench for demux_4_stream: driver queues expected beats, a negedge monitor checks every transfer.
// Directed cases plus randomized packets; counter wrap test runs when DEMUX_4_BEAT_CNT_EN is defined.
module tb_demux_4_stream;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   sel = 2'd0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = 4'b1111;
`ifdef DEMUX_4_BEAT_CNT_EN
  logic [63:0]  beat_cnt;
`endif

  demux_4_stream #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef DEMUX_4_BEAT_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
    logic [1:0]   dest;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  bit    rdy_random = 1'b0;
  logic  in_pkt = 1'b0;
  logic [1:0] pkt_dest = 2'd0;
  logic [3:0][15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: sampled mid-cycle when all inputs are stable.
  always @(negedge clk) begin
    beat_t b;
    beat_t e;
    int    d;
    if (!rst_n) begin
      q.delete();
      in_pkt  = 1'b0;
      exp_cnt = '0;
    end else begin
      chk("onehot", {63'd0, $onehot0(out_valid)}, 64'd1);
      chk("in_ready", {63'd0, in_ready},
          {63'd0, (q.size() == 0) || out_ready[q.size() != 0 ? q[0].dest : 2'd0]});
      if (|(out_valid & out_ready)) begin
        d = 0;
        for (int i = 0; i < 4; i++) if (out_valid[i]) d = i;
        if (q.size() == 0) begin
          chk("unexpected_beat", {60'd0, out_valid}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("out_data", {56'd0, out_data}, {56'd0, e.d});
          chk("out_last", {63'd0, out_last}, {63'd0, e.l});
          chk("dest", 64'(d), {62'd0, e.dest});
          exp_cnt[d] = exp_cnt[d] + 16'd1;
        end
      end
      if (in_valid && in_ready) begin
        b.d    = in_data;
        b.l    = in_last;
        b.dest = in_pkt ? pkt_dest : sel;
        q.push_back(b);
        pkt_dest = b.dest;
        in_pkt   = !in_last;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_random) out_ready = 4'($urandom);
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, input logic [1:0] s,
                      output int waits);
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    sel      = s;
    waits    = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (!acc) waits++;
    end while (!acc && waits < 1000);
    if (!acc) chk("send_timeout", 64'(waits), 64'd0);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    sel      = 2'($urandom);
  endtask

  task automatic drain_all();
    int n = 0;
    rdy_random = 1'b0;
    out_ready  = 4'b1111;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
    chk("rst_out_data", {56'd0, out_data}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int w;
    int len;
    logic [1:0] s;
    #2;
    do_reset();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single beat to channel 2.
    out_ready = 4'b1111;
    send(8'hA5, 1'b1, 2'd2, w);
    @(negedge clk);
    chk("single_valid", {60'd0, out_valid}, 64'h4);
    chk("single_data", {56'd0, out_data}, 64'hA5);
    chk("single_last", {63'd0, out_last}, 64'd1);
    step();
    @(negedge clk);
    chk("single_empty", {60'd0, out_valid}, 64'd0);
    step();

    // Packet lock: sel changes mid-packet, next packet follows with no bubble.
    send(8'h01, 1'b0, 2'd1, w);
    send(8'h02, 1'b0, 2'd3, w);
    send(8'h03, 1'b0, 2'd3, w);
    send(8'h04, 1'b1, 2'd3, w);
    send(8'h10, 1'b1, 2'd3, w);
    chk("lock_no_bubble", 64'(w), 64'd0);
    drain_all();

    // Backpressure on channel 0; other ready bits toggle freely.
    out_ready = 4'b1110;
    send(8'h21, 1'b0, 2'd0, w);
    in_valid = 1'b1;
    in_data  = 8'h22;
    in_last  = 1'b1;
    sel      = 2'd2;
    repeat (3) begin
      out_ready = {3'($urandom), 1'b0};
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold", {56'd0, out_data}, 64'h21);
      @(posedge clk);
      #1;
    end
    out_ready = 4'b0001;
    @(negedge clk);
    chk("bp_release", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second", {56'd0, out_data}, 64'h22);
    chk("bp_second_ch", {60'd0, out_valid}, 64'h1);
    step();
    drain_all();

    // Throughput: 16 beats to channel 3 with every send accepted first try.
    for (int i = 0; i < 16; i++) begin
      send(8'(i + 8'h40), 1'(i == 15), (i == 0) ? 2'd3 : 2'($urandom), w);
      chk("thru_stall", 64'(w), 64'd0);
    end
    drain_all();

    // Reset in the middle of a packet.
    send(8'h31, 1'b0, 2'd1, w);
    send(8'h32, 1'b0, 2'd1, w);
    do_reset();
    send(8'h55, 1'b1, 2'd0, w);
    @(negedge clk);
    chk("post_rst_ch0", {60'd0, out_valid}, 64'h1);
    step();
    drain_all();

    // Randomized packets with random gaps and random consumer readiness.
    rdy_random = 1'b1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 6);
      s   = 2'($urandom);
      for (int b = 0; b < len; b++) begin
        send(8'($urandom), 1'(b == len - 1), (b == 0) ? s : 2'($urandom), w);
        if ($urandom_range(0, 3) == 0) step();
      end
    end
    drain_all();

`ifdef DEMUX_4_BEAT_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) send(8'(i), 1'b1, 2'd1, w);
    for (int i = 0; i < 65537; i++) send(8'(i), 1'b1, 2'd2, w);
    drain_all();
    step();
    chk("cnt_plan", beat_cnt, {16'd0, 16'd1, 16'd3, 16'd0});
    chk("cnt_model", beat_cnt, exp_cnt);
`endif

    chk("leftover", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_4_stream.md
Name: demux_4_stream

Overview:
- 1-to-4 stream demultiplexer. It is the distribution counterpart of the 4:1 selection mux and is used wherever one producer feeds one of four consumers.
- Accepts a valid/ready beat stream with packet framing (last). Routes each packet to the output channel chosen by sel.
- The destination is locked for the whole packet.
- One registered output stage (a single-entry buffer) breaks the combinational path from input to output.

Parameters:
- width, 1, data bits per beat.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  2  destination channel; sampled only on the first beat of a packet.
- in_data  input  width  input beat data.
- in_valid  input  1  input beat valid.
- in_last  input  1  final beat of the packet.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  width  registered beat data, shared by all channels.
- out_last  output  1  registered last flag, shared.
- out_valid  output  4  one-hot; bit i set means the buffered beat is for channel i.
- out_ready  input  4  per-channel consumer ready.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally):
  - buffer empty; out_valid=4'b0000, out_data=0, out_last=0.
  - FSM=IDLE, lock_sel=0.
  - Any partially routed packet is discarded; the next accepted beat is treated as a packet start.
- Buffer: one entry {data, last, dest[1:0]}, full flag.
  - out_valid[i] = full && dest==i; never more than one bit set.
  - Output drain: a transfer occurs when out_valid[dest] && out_ready[dest]. out_ready bits of non-destination channels are ignored.
  - in_ready = !full || out_ready[dest]. This is a combinational ready path, allowing one beat per cycle at full throughput.
  - Input accept: in_valid && in_ready. On accept, the buffer loads {in_data, in_last, route} and full=1.
  - If the buffer drains with no accept in the same cycle, full=0. Simultaneous drain and accept keeps full=1 with the new contents.
  - Latency: an accepted beat appears on out_* the cycle after acceptance.
- route = sel in IDLE, lock_sel in LOCKED.
- FSM:
  - IDLE: accept with in_last=0 -> lock_sel<=sel, go LOCKED. Accept with in_last=1 is a single-beat packet; stay IDLE.
  - LOCKED: sel is ignored. Accept with in_last=1 -> IDLE. Otherwise stay LOCKED.
  - No accept -> state unchanged.
- in_valid low: no state change; in_data, in_last and sel are don't-care.
- A stalled destination blocks all channels; no reordering, no drop.
- out_data/out_last hold their last loaded value when the buffer is empty. Consumers qualify them with out_valid only.
- sel changing mid-packet has no effect. Back-to-back packets may target different channels with no idle cycle.

Optional Feature:
- Macro DEMUX_4_BEAT_CNT_EN.
- Defined:
  - Adds output port beat_cnt [63:0], four 16-bit counters; channel i at bits [16*i+15:16*i].
  - Counter i increments by 1 on each output transfer to channel i and wraps 16'hFFFF -> 0.
  - Reset clears all counters to 0.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Single beat: reset, all out_ready=1; send 1 beat, sel=2, in_data=8'hA5, last=1 (width=8) -> next cycle out_valid=4'b0100, out_data=8'hA5, out_last=1; following cycle out_valid=0.
- Packet lock: send 4-beat packet 8'h01..8'h04 with sel=1, changing sel to 3 after the first beat -> all 4 beats on out_valid=4'b0010, last on 8'h04. Next packet with sel=3 goes to 4'b1000 with no bubble.
- Backpressure:
  - out_ready[0]=0 while sending 2 beats to ch0 -> beat 1 held in the buffer, in_ready=0, beat 2 not taken.
  - Raise out_ready[0] -> beat 1 drains and beat 2 is accepted in the same cycle; 2 beats out in 2 consecutive cycles.
  - Other out_ready bits toggling have no effect.
- Throughput: 16-beat packet to ch3 with out_ready=4'b1111 -> in_ready stays 1 throughout, 16 consecutive output cycles.
- Reset mid-packet: assert rst_n low after beat 2 of a 4-beat sel=1 packet -> out_valid=0 immediately (async). After release, a beat with sel=0 is routed to 4'b0001.
- DEMUX_4_BEAT_CNT_EN: send 3 beats to ch1 and 65537 beats to ch2 -> beat_cnt[31:16]=3, beat_cnt[47:32]=1 (wrap), others 0.
